// File: rtl/washing_machine_ctrl.sv
// Sequencing FSM for a single-drum washer: one soap wash, then one water rinse, then spin.
// Plant sensors and external timers are sampled each clock; the block itself counts nothing.
//
// state     | meaning
// IDLE      | waiting for start with the door closed
// FILL      | fill valve open until drum full
// DETERGENT | waiting for detergent dispense confirmation
// WASH      | agitation until external cycle timer expires
// DRAIN     | drain valve open until drum empty
// SPIN      | motor and drain until external spin timer expires
// DONE      | program complete, door unlocked, waiting for start release
module washing_machine_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic door_close,
  input  logic start,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_value_on,
  output logic drain_value_on,
  output logic done,
  output logic soap_wash,
  output logic water_wash
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    DETERGENT = 3'd2,
    WASH      = 3'd3,
    DRAIN     = 3'd4,
    SPIN      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t state, state_nx;
  logic   soap_f, soap_nx;
  logic   water_f, water_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      soap_f  <= 1'b0;
      water_f <= 1'b0;
    end else begin
      state   <= state_nx;
      soap_f  <= soap_nx;
      water_f <= water_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    soap_nx        = soap_f;
    water_nx       = water_f;
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start && door_close) state_nx = FILL;
      end
      FILL: begin
        door_lock     = 1'b1;
        fill_value_on = 1'b1;
        if (filled) begin
          // A second fill after the soap wash is the rinse fill.
          if (soap_f) begin
            state_nx = WASH;
            water_nx = 1'b1;
          end else begin
            state_nx = DETERGENT;
          end
        end
      end
      DETERGENT: begin
        door_lock = 1'b1;
        if (detergent_added) begin
          state_nx = WASH;
          soap_nx  = 1'b1;
        end
      end
      WASH: begin
        door_lock = 1'b1;
        motor_on  = 1'b1;
        if (cycle_timeout) state_nx = DRAIN;
      end
      DRAIN: begin
        door_lock      = 1'b1;
        drain_value_on = 1'b1;
        if (drained) state_nx = water_f ? SPIN : FILL;
      end
      SPIN: begin
        door_lock      = 1'b1;
        motor_on       = 1'b1;
        drain_value_on = 1'b1;
        if (spin_timeout) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        // Require start to be released so a held button never restarts the program.
        if (!start) begin
          state_nx = IDLE;
          soap_nx  = 1'b0;
          water_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        soap_nx  = 1'b0;
        water_nx = 1'b0;
      end
    endcase
  end

  assign soap_wash  = soap_f;
  assign water_wash = water_f;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Directed bench for washing_machine_ctrl: expected output vectors are queued as each
// input step is driven and compared one cycle later against the registered outputs.
module tb_washing_machine_ctrl;

  logic clk, reset;
  logic door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout;
  logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;

  int checks   = 0;
  int failures = 0;

  logic [6:0] sb_q[$];
  string      tag_q[$];

  localparam int S_IDLE = 0, S_FILL = 1, S_DET = 2, S_WASH = 3, S_DRAIN = 4, S_SPIN = 5, S_DONE = 6;

  washing_machine_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .door_close     (door_close),
    .start          (start),
    .filled         (filled),
    .detergent_added(detergent_added),
    .cycle_timeout  (cycle_timeout),
    .drained        (drained),
    .spin_timeout   (spin_timeout),
    .door_lock      (door_lock),
    .motor_on       (motor_on),
    .fill_value_on  (fill_value_on),
    .drain_value_on (drain_value_on),
    .done           (done),
    .soap_wash      (soap_wash),
    .water_wash     (water_wash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {door_lock, motor_on, fill, drain, done, soap_wash, water_wash} expected for a state
  function automatic logic [6:0] ev(int st, bit s, bit w);
    logic lk, mo, fi, dr, dn;
    lk = (st == S_FILL) || (st == S_DET) || (st == S_WASH) || (st == S_DRAIN) || (st == S_SPIN);
    mo = (st == S_WASH) || (st == S_SPIN);
    fi = (st == S_FILL);
    dr = (st == S_DRAIN) || (st == S_SPIN);
    dn = (st == S_DONE);
    return {lk, mo, fi, dr, dn, s, w};
  endfunction

  task automatic set_in(bit dc, bit st, bit fl, bit da, bit ct, bit dr, bit sp);
    door_close      = dc;
    start           = st;
    filled          = fl;
    detergent_added = da;
    cycle_timeout   = ct;
    drained         = dr;
    spin_timeout    = sp;
  endtask

  task automatic step(string tag, logic [6:0] exp_v);
    logic [6:0] obs, e;
    string      t;
    sb_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs = {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};
    e   = sb_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (obs === e)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 1, 1, 1, 1, 1, 1);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      set_in($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
             $urandom_range(1), $urandom_range(1), $urandom_range(1));
      step("reset", ev(S_IDLE, 0, 0));
    end
    reset = 1'b0;
    set_in(1, 0, 1, 1, 1, 1, 1);
    step("idle_no_start", ev(S_IDLE, 0, 0));
    step("idle_no_start", ev(S_IDLE, 0, 0));

    // Start interlock
    set_in(0, 1, 0, 0, 0, 0, 0);
    step("interlock_open_door", ev(S_IDLE, 0, 0));
    step("interlock_open_door", ev(S_IDLE, 0, 0));
    set_in(1, 1, 0, 0, 0, 0, 0);
    step("enter_fill", ev(S_FILL, 0, 0));

    // Stall run
    for (int i = 0; i < 5; i++) step("stall_fill", ev(S_FILL, 0, 0));
    filled = 1'b1;
    step("enter_det", ev(S_DET, 0, 0));
    for (int i = 0; i < 5; i++) step("stall_det", ev(S_DET, 0, 0));
    filled = 1'b0;
    detergent_added = 1'b1;
    step("enter_wash1", ev(S_WASH, 1, 0));
    detergent_added = 1'b0;
    door_close = 1'b0;
    for (int i = 0; i < 5; i++) step("stall_wash_door_open", ev(S_WASH, 1, 0));
    cycle_timeout = 1'b1;
    step("enter_drain1", ev(S_DRAIN, 1, 0));
    cycle_timeout = 1'b0;
    for (int i = 0; i < 5; i++) step("stall_drain", ev(S_DRAIN, 1, 0));
    drained = 1'b1;
    step("enter_rinse_fill", ev(S_FILL, 1, 0));
    drained = 1'b0;
    filled  = 1'b1;
    step("enter_wash2", ev(S_WASH, 1, 1));
    filled = 1'b0;
    cycle_timeout = 1'b1;
    step("enter_drain2", ev(S_DRAIN, 1, 1));
    cycle_timeout = 1'b0;
    drained = 1'b1;
    step("enter_spin", ev(S_SPIN, 1, 1));
    drained = 1'b0;
    for (int i = 0; i < 5; i++) step("stall_spin", ev(S_SPIN, 1, 1));
    spin_timeout = 1'b1;
    step("enter_done", ev(S_DONE, 1, 1));
    for (int i = 0; i < 3; i++) step("done_hold_start", ev(S_DONE, 1, 1));
    start = 1'b0;
    step("done_to_idle", ev(S_IDLE, 0, 0));

    // Nominal run with every input held high
    set_in(1, 1, 1, 1, 1, 1, 1);
    step("nom_fill", ev(S_FILL, 0, 0));
    step("nom_det", ev(S_DET, 0, 0));
    step("nom_wash1", ev(S_WASH, 1, 0));
    step("nom_drain1", ev(S_DRAIN, 1, 0));
    step("nom_fill2", ev(S_FILL, 1, 0));
    step("nom_wash2", ev(S_WASH, 1, 1));
    step("nom_drain2", ev(S_DRAIN, 1, 1));
    step("nom_spin", ev(S_SPIN, 1, 1));
    step("nom_done", ev(S_DONE, 1, 1));
    step("nom_done_hold", ev(S_DONE, 1, 1));
    step("nom_done_hold", ev(S_DONE, 1, 1));
    start = 1'b0;
    step("nom_to_idle", ev(S_IDLE, 0, 0));

    // Restart: soap flag must be set again via DETERGENT
    set_in(1, 1, 1, 1, 0, 0, 0);
    step("re_fill", ev(S_FILL, 0, 0));
    step("re_det", ev(S_DET, 0, 0));
    step("re_wash", ev(S_WASH, 1, 0));
    step("re_wash_hold", ev(S_WASH, 1, 0));

    // Mid-run reset
    reset = 1'b1;
    step("midrun_reset", ev(S_IDLE, 0, 0));
    reset = 1'b0;
    start = 1'b0;
    step("after_reset_idle", ev(S_IDLE, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/washing_machine_ctrl.md
Name: washing_machine_ctrl

Overview:
Control FSM for a single-drum washing machine. It sequences lock, fill, detergent, wash, drain, rinse and spin, driven by level-sensitive sensor/timer inputs from the plant, and drives the valve, motor and lock actuators. The full cycle is one soap wash followed by one water rinse. External timers and sensors sit outside the block; it counts nothing itself.

Parameters:
none

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
door_close  input  1  door-closed sensor
start  input  1  user start request (level)
filled  input  1  drum-full sensor
detergent_added  input  1  detergent-dispensed confirmation
cycle_timeout  input  1  external wash/rinse agitation timer expired
drained  input  1  drum-empty sensor
spin_timeout  input  1  external spin timer expired
door_lock  output  1  door lock solenoid
motor_on  output  1  drum motor enable
fill_value_on  output  1  fill valve open
drain_value_on  output  1  drain valve open
done  output  1  program complete indication
soap_wash  output  1  flag: soap wash phase has been performed
water_wash  output  1  flag: rinse phase has been entered

Behaviour:
- Registered state plus two registered flags (soap_f, water_f). Outputs are decoded combinationally from the current state; soap_wash = soap_f, water_wash = water_f. Glitch-free because they depend on registers only.
- Reset (sync, active-high): state IDLE, soap_f = 0, water_f = 0. Every output is 0. Reset overrides all other inputs and aborts any phase; the door unlocks on the next cycle.
- At most one transition per clock. Every input is sampled at the rising edge, so there is a one-cycle latency from input to state/output change.
- States, their outputs and their transitions (outputs not listed are 0):
  - IDLE: all 0. If start=1 and door_close=1, go to FILL. Otherwise stay.
  - FILL: door_lock=1, fill_value_on=1. When filled=1: if soap_f=0, go to DETERGENT. If soap_f=1, go to WASH and set water_f=1.
  - DETERGENT: door_lock=1. When detergent_added=1, go to WASH and set soap_f=1.
  - WASH: door_lock=1, motor_on=1. When cycle_timeout=1, go to DRAIN.
  - DRAIN: door_lock=1, drain_value_on=1. When drained=1: if water_f=0, go to FILL (rinse fill). If water_f=1, go to SPIN.
  - SPIN: door_lock=1, motor_on=1, drain_value_on=1. When spin_timeout=1, go to DONE.
  - DONE: done=1, door_lock=0. Flags are held, so soap_wash=1 and water_wash=1 remain visible. When start=0, go to IDLE and clear both flags. While start stays 1 the block remains in DONE, so a held start never auto-restarts.
- door_close is examined only in IDLE. Once running, the door is locked and door_close is ignored.
- start is examined only in IDLE and DONE.
- Inputs irrelevant to the current state are ignored, even if already high. For example, if filled is still 1 when the rinse FILL is entered, FILL advances after one cycle.
- Illegal or unused state encodings recover to IDLE on the next clock, with flags cleared.

Test Plan:
- Reset: assert reset for 2 cycles with all inputs at random values -> all seven outputs 0. Deassert reset, keep start=0 -> the block stays IDLE and outputs stay 0.
- Start interlock: start=1, door_close=0 -> stays IDLE, door_lock=0. Then raise door_close=1 -> the next cycle door_lock=1, fill_value_on=1.
- Nominal full run: all inputs held 1 from start -> the state sequence FILL, DETERGENT, WASH, DRAIN, FILL, WASH, DRAIN, SPIN, DONE occurs on consecutive cycles 1..9. soap_wash rises when entering the first WASH. water_wash rises when entering the second WASH. In SPIN, motor_on=1 and drain_value_on=1 together. In DONE, done=1 and door_lock=0. The block stays in DONE while start=1.
- Stalls: hold filled=0 for 5 cycles in FILL -> fill_value_on stays 1 and the state is unchanged. Repeat for detergent_added, cycle_timeout, drained and spin_timeout in their respective states.
- Return to idle: in DONE, drop start -> the next cycle is IDLE with done=0, soap_wash=0, water_wash=0. Restart -> soap_wash must be set again by DETERGENT.
- Mid-run reset: assert reset during WASH -> the next cycle all outputs are 0 and the flags are cleared. Drop door_close during WASH (no reset) -> no effect, door_lock stays 1.
